// File: rtl/sha_block_builder.sv
// Streaming SHA-256 front end: FIPS 180-4 padding of a byte stream
// into 512-bit blocks tagged first/last.
module sha_block_builder #(
    parameter int LEN_BYTES_W = 61
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_first,
    output logic         blk_last,
    output logic         busy
);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [6:0]             idx_q, idx_d;
    logic [LEN_BYTES_W-1:0] count_q, count_d;
    logic                   first_q, first_d;
    logic                   tail_q, tail_d;
    logic                   mark_q, mark_d;
    logic [511:0]           blk_q, blk_d;

    logic                   has_byte;
    logic [6:0]             q;
    logic [LEN_BYTES_W-1:0] cnt_inc;

    function automatic logic [63:0] bit_len(input logic [LEN_BYTES_W-1:0] c);
        bit_len = 64'({c, 3'b000});
    endfunction

    assign has_byte = !(in_last && in_empty);
    assign q        = idx_q + {6'd0, has_byte};
    assign cnt_inc  = count_q + LEN_BYTES_W'(has_byte);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        first_d = first_q;
        tail_d  = tail_q;
        mark_d  = mark_q;
        blk_d   = blk_q;
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    if (has_byte) begin
                        for (int b = 0; b < 64; b++) begin
                            if (idx_q == 7'(b)) blk_d[511-8*b -: 8] = in_data;
                        end
                    end
                    idx_d   = q;
                    count_d = cnt_inc;
                    if (in_last) begin
                        // Marker at q, zeros after it; length overlays 56..63 if it fits.
                        for (int b = 0; b < 64; b++) begin
                            if (7'(b) == q)     blk_d[511-8*b -: 8] = 8'h80;
                            else if (7'(b) > q) blk_d[511-8*b -: 8] = 8'h00;
                        end
                        if (q <= 7'd55) begin
                            blk_d[63:0] = bit_len(cnt_inc);
                            state_d     = S_LAST;
                        end else begin
                            state_d = S_EMIT;
                            tail_d  = 1'b1;
                            mark_d  = (q == 7'd64);
                        end
                    end else if (q == 7'd64) begin
                        state_d = S_EMIT;
                        tail_d  = 1'b0;
                    end
                end
            end
            S_EMIT: begin
                if (blk_ready) begin
                    first_d = 1'b0;
                    if (!tail_q) begin
                        idx_d   = 7'd0;
                        state_d = S_FILL;
                    end else begin
                        blk_d   = {(mark_q ? 8'h80 : 8'h00), 440'd0, bit_len(count_q)};
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (blk_ready) begin
                    idx_d   = 7'd0;
                    count_d = '0;
                    tail_d  = 1'b0;
                    mark_d  = 1'b0;
                    first_d = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            idx_q   <= 7'd0;
            count_q <= '0;
            first_q <= 1'b1;
            tail_q  <= 1'b0;
            mark_q  <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            first_q <= first_d;
            tail_q  <= tail_d;
            mark_q  <= mark_d;
            blk_q   <= blk_d;
        end
    end

    assign in_ready  = (state_q == S_FILL) && !reset;
    assign blk_valid = (state_q != S_FILL);
    assign blk_data  = blk_q;
    assign blk_first = first_q && blk_valid;
    assign blk_last  = (state_q == S_LAST);
    assign busy      = (idx_q != 7'd0) || (count_q != '0) || (state_q != S_FILL);

endmodule

// File: tb/tb_sha_block_builder.sv
// Bench for sha_block_builder: padding model feeds a block scoreboard,
// scenario tasks add direct checks.
module tb_sha_block_builder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_empty = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         busy;

    sha_block_builder dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_empty(in_empty),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    int           blk_cnt = 0;
    logic [511:0] last_data = '0;
    logic         last_first = 1'b0;
    logic         last_last = 1'b0;
    bit           bp_mode = 1'b0;
    int           wcnt = 0;
    bit           pv;
    bit           stall = 1'b0;
    logic [511:0] sd;
    logic         sf, sl;

    // Downstream readiness: optionally stall each block for 5 cycles.
    initial forever begin
        @(negedge clk);
        pv = blk_valid && blk_ready;
        @(posedge clk);
        #1;
        if (pv) wcnt = 0;
        if (bp_mode && wcnt < 5) begin
            blk_ready = 1'b0;
            if (blk_valid) wcnt++;
        end else begin
            blk_ready = 1'b1;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (blk_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL in_ready_emit got=%b exp=0", in_ready);
                end
            end
            if (stall && blk_valid) begin
                checks++;
                if (blk_data !== sd || blk_first !== sf || blk_last !== sl) begin
                    failures++;
                    $display("FAIL stable got=%h/%b%b exp=%h/%b%b",
                             blk_data, blk_first, blk_last, sd, sf, sl);
                end
            end
            if (blk_valid && blk_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_block got=%h", blk_data);
                end else begin
                    e = sb.pop_front();
                    if (blk_data !== e.d || blk_first !== e.f || blk_last !== e.l) begin
                        failures++;
                        $display("FAIL block got=%h/%b%b exp=%h/%b%b",
                                 blk_data, blk_first, blk_last, e.d, e.f, e.l);
                    end
                end
                last_data  = blk_data;
                last_first = blk_first;
                last_last  = blk_last;
                blk_cnt++;
            end
            stall = blk_valid && !blk_ready;
            sd = blk_data;
            sf = blk_first;
            sl = blk_last;
        end
    end

    function automatic void push_expected(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  len;
        logic [511:0] d;
        exp_t         e;
        int           nb;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        nb = p.size() / 64;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 64; i++) d[511-8*i -: 8] = p[64*k+i];
            e.d = d;
            e.f = (k == 0);
            e.l = (k == nb - 1);
            sb.push_back(e);
        end
    endfunction

    task automatic drive_beat(input logic [7:0] d, input bit last, input bit empty,
                              input bit gaps);
        bit acc;
        acc = 1'b0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL beat_timeout got=not_accepted exp=accepted");
        end
    endtask

    // mode 0: no terminator, 1: in_last on final byte, 2: empty terminator beat
    task automatic send_msg(input logic [7:0] msg[$], input int mode, input bit gaps);
        if (mode != 0) push_expected(msg);
        for (int i = 0; i < msg.size(); i++)
            drive_beat(msg[i], (mode == 1) && (i == msg.size() - 1), 1'b0, gaps);
        if (mode == 2 || (mode == 1 && msg.size() == 0))
            drive_beat(8'h00, 1'b1, 1'b1, gaps);
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !blk_valid;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain got=pending=%0d exp=0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL in_ready_in_reset got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || blk_valid !== 1'b0 || busy !== 1'b0 ||
            blk_first !== 1'b0 || blk_last !== 1'b0 || blk_data !== 512'd0) begin
            failures++;
            $display("FAIL reset_state got=rdy%b v%b busy%b f%b l%b d%h exp=rdy1 v0 busy0 f0 l0 d0",
                     in_ready, blk_valid, busy, blk_first, blk_last, blk_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_abc();
        logic [7:0] m[$];
        int n0;
        m = '{8'h61, 8'h62, 8'h63};
        n0 = blk_cnt;
        send_msg(m, 1, 1'b0);
        @(negedge clk);
        checks++;
        if (blk_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abc_latency got=v%b busy%b exp=v1 busy1", blk_valid, busy);
        end
        wait_drain("abc");
        checks++;
        if (last_data !== {32'h61626380, 416'd0, 64'h18} || !last_first || !last_last ||
            blk_cnt - n0 != 1) begin
            failures++;
            $display("FAIL abc_block got=%h/%b%b n=%0d exp=61626380..18/11 n=1",
                     last_data, last_first, last_last, blk_cnt - n0);
        end
    endtask

    task automatic test_empty();
        logic [7:0] m[$];
        m = {};
        send_msg(m, 1, 1'b0);
        wait_drain("empty");
        checks++;
        if (last_data !== {8'h80, 504'd0} || !last_first || !last_last) begin
            failures++;
            $display("FAIL empty_block got=%h/%b%b exp=80..0/11", last_data, last_first, last_last);
        end
    endtask

    task automatic test_55_56();
        logic [7:0] m[$];
        int n0;
        m = {};
        for (int i = 0; i < 55; i++) m.push_back(8'h41);
        send_msg(m, 1, 1'b0);
        wait_drain("len55");
        checks++;
        if (last_data[63:0] !== 64'h1B8 || last_data[511-8*55 -: 8] !== 8'h80) begin
            failures++;
            $display("FAIL len55 got=len%h b55=%h exp=len1b8 b55=80",
                     last_data[63:0], last_data[511-8*55 -: 8]);
        end
        m.push_back(8'h41);
        n0 = blk_cnt;
        send_msg(m, 1, 1'b0);
        wait_drain("len56");
        checks++;
        if (last_data !== {448'd0, 64'h1C0} || last_first || !last_last || blk_cnt - n0 != 2) begin
            failures++;
            $display("FAIL len56 got=%h/%b%b n=%0d exp=0..1c0/01 n=2",
                     last_data, last_first, last_last, blk_cnt - n0);
        end
    endtask

    task automatic test_64_200();
        logic [7:0] m[$];
        int n0;
        m = {};
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        n0 = blk_cnt;
        send_msg(m, 1, 1'b0);
        wait_drain("len64");
        checks++;
        if (last_data !== {8'h80, 440'd0, 64'h200} || blk_cnt - n0 != 2) begin
            failures++;
            $display("FAIL len64 got=%h n=%0d exp=80..200 n=2", last_data, blk_cnt - n0);
        end
        m = {};
        for (int i = 0; i < 200; i++) m.push_back(8'($urandom));
        n0 = blk_cnt;
        send_msg(m, 1, 1'b1);
        wait_drain("len200");
        checks++;
        if (last_data[63:0] !== 64'h640 || blk_cnt - n0 != 4) begin
            failures++;
            $display("FAIL len200 got=len%h n=%0d exp=len640 n=4", last_data[63:0], blk_cnt - n0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] m[$];
        int n0;
        m = {};
        for (int i = 0; i < 120; i++) m.push_back(8'($urandom));
        bp_mode = 1'b1;
        n0 = blk_cnt;
        send_msg(m, 1, 1'b1);
        wait_drain("bp");
        bp_mode = 1'b0;
        checks++;
        if (blk_cnt - n0 != 3) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=3", blk_cnt - n0);
        end
    endtask

    task automatic test_empty_term();
        logic [7:0] m[$];
        m = '{8'h61, 8'h62};
        send_msg(m, 2, 1'b1);
        wait_drain("eterm");
        checks++;
        if (last_data !== {32'h61628000, 416'd0, 64'h10}) begin
            failures++;
            $display("FAIL eterm_block got=%h exp=61628000..10", last_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m[$];
        int n0;
        m = {};
        for (int i = 0; i < 30; i++) m.push_back(8'h5A);
        send_msg(m, 0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_partial got=%b exp=1", busy);
        end
        do_reset();
        m = '{8'h61, 8'h62, 8'h63};
        n0 = blk_cnt;
        send_msg(m, 1, 1'b0);
        wait_drain("rst_abc");
        checks++;
        if (blk_cnt - n0 != 1 || !last_first || last_data[63:0] !== 64'h18 ||
            last_data[511:480] !== 32'h61626380) begin
            failures++;
            $display("FAIL rst_abc got=n%0d f%b len%h exp=n1 f1 len18",
                     blk_cnt - n0, last_first, last_data[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[$];
        int n;
        for (int k = 0; k < 4; k++) begin
            m = {};
            n = $urandom_range(0, 130);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            send_msg(m, 1, k[0]);
        end
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_55_56();
        test_64_200();
        test_backpressure();
        test_empty_term();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
